// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory stage: widths, access-size encodings, FSM states and
// the alignment rule used to reject an access before it reaches the bus.
package lsu_mem_stage_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned RD_W = 5;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;
  localparam logic [1:0] LSU_SZ_D = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StRsp  = 2'b10,
    StDone = 2'b11
  } lsu_state_e;

  // An access is misaligned when its byte offset is not a multiple of its size.
  function automatic logic lsu_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      LSU_SZ_B: mis = 1'b0;
      LSU_SZ_H: mis = off[0];
      LSU_SZ_W: mis = |off[1:0];
      default:  mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational data alignment for the LSU: store lane shift and strobes, load byte extract
// with sign/zero extension, and the misalignment check for an incoming op.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_chk_off,
  input  logic [1:0]      i_chk_size,
  output logic [XLEN-1:0] o_wdata,
  output logic [7:0]      o_wstrb,
  output logic [XLEN-1:0] o_ld_data,
  output logic            o_misalign
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_rsh;
  logic [7:0]      w_mask;
  logic            w_sext;

  assign w_shamt    = {i_off, 3'b000};
  assign o_wdata    = i_wdata << w_shamt;
  assign w_rsh      = i_rdata >> w_shamt;
  assign o_wstrb    = w_mask << i_off;
  assign w_sext     = ~i_unsigned;
  assign o_misalign = lsu_misaligned(i_chk_off, i_chk_size);

  always_comb begin
    w_mask    = 8'hFF;
    o_ld_data = w_rsh;
    case (i_size)
      LSU_SZ_B: begin
        w_mask    = 8'h01;
        o_ld_data = {{56{w_sext & w_rsh[7]}}, w_rsh[7:0]};
      end
      LSU_SZ_H: begin
        w_mask    = 8'h03;
        o_ld_data = {{48{w_sext & w_rsh[15]}}, w_rsh[15:0]};
      end
      LSU_SZ_W: begin
        w_mask    = 8'h0F;
        o_ld_data = {{32{w_sext & w_rsh[31]}}, w_rsh[31:0]};
      end
      default: begin
        w_mask    = 8'hFF;
        o_ld_data = w_rsh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: latches an EX op, issues one aligned 64-bit bus request for loads/stores,
// and presents the writeback result through a valid/ready handshake.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_in_alu_res,
  input  logic [XLEN-1:0] i_in_wdata,
  input  logic            i_in_is_load,
  input  logic            i_in_is_store,
  input  logic [1:0]      i_in_size,
  input  logic            i_in_unsigned,
  input  logic [RD_W-1:0] i_in_rd,
  input  logic            i_in_wen,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_req_addr,
  output logic            o_mem_req_we,
  output logic [XLEN-1:0] o_mem_req_wdata,
  output logic [7:0]      o_mem_req_wstrb,
  input  logic            i_mem_rsp_valid,
  input  logic [XLEN-1:0] i_mem_rsp_rdata,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [RD_W-1:0] o_out_rd,
  output logic            o_out_wen,
  output logic [XLEN-1:0] o_out_data,
  output logic            o_out_misalign
);

  lsu_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic            r_is_load, r_is_store, r_unsigned, r_wen;
  logic [1:0]      r_size;
  logic [RD_W-1:0] r_rd;
  logic [XLEN-1:0] r_out_data;
  logic            r_out_wen, r_out_misalign;
  logic [RD_W-1:0] r_out_rd;

  logic            w_accept, w_in_mem, w_in_misal, w_rsp_take;
  logic [XLEN-1:0] w_ld_data;

  lsu_align u_align (
    .i_off      (r_addr[2:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (i_mem_rsp_rdata),
    .i_chk_off  (i_in_alu_res[2:0]),
    .i_chk_size (i_in_size),
    .o_wdata    (o_mem_req_wdata),
    .o_wstrb    (o_mem_req_wstrb),
    .o_ld_data  (w_ld_data),
    .o_misalign (w_in_misal)
  );

  assign w_accept   = o_in_ready & i_in_valid;
  assign w_in_mem   = i_in_is_load | i_in_is_store;
  assign w_rsp_take = (r_state == StRsp) & i_mem_rsp_valid;

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    case (r_state)
      StIdle: o_in_ready = 1'b1;
      StReq:  if (i_mem_req_ready) w_state_nxt = StRsp;
      StRsp:  if (i_mem_rsp_valid) w_state_nxt = StDone;
      StDone: begin
        o_in_ready = i_out_ready;
        if (i_out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Accepting in DONE takes the same decision as IDLE, so a new op overrides the return.
    if (w_accept) w_state_nxt = (w_in_mem & ~w_in_misal) ? StReq : StDone;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_size     <= LSU_SZ_B;
      r_unsigned <= 1'b0;
      r_rd       <= '0;
      r_wen      <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= i_in_alu_res;
      r_wdata    <= i_in_wdata;
      r_is_load  <= i_in_is_load;
      r_is_store <= i_in_is_store;
      r_size     <= i_in_size;
      r_unsigned <= i_in_unsigned;
      r_rd       <= i_in_rd;
      r_wen      <= i_in_wen;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data     <= '0;
      r_out_wen      <= 1'b0;
      r_out_misalign <= 1'b0;
      r_out_rd       <= '0;
    end else if (w_accept) begin
      r_out_rd <= i_in_rd;
      if (!w_in_mem) begin
        r_out_data     <= i_in_alu_res;
        r_out_wen      <= i_in_wen;
        r_out_misalign <= 1'b0;
      end else if (w_in_misal) begin
        r_out_data     <= '0;
        r_out_wen      <= 1'b0;
        r_out_misalign <= 1'b1;
      end
    end else if (w_rsp_take) begin
      // Store acks carry no data; a load/store conflict is treated as a load.
      r_out_data     <= r_is_load ? w_ld_data : '0;
      r_out_wen      <= r_is_load & r_wen;
      r_out_misalign <= 1'b0;
    end
  end

  assign o_mem_req_valid = (r_state == StReq);
  assign o_mem_req_addr  = {r_addr[XLEN-1:3], 3'b000};
  assign o_mem_req_we    = r_is_store & ~r_is_load;
  assign o_out_valid     = (r_state == StDone);
  assign o_out_rd        = r_out_rd;
  assign o_out_wen       = r_out_wen;
  assign o_out_data      = r_out_data;
  assign o_out_misalign  = r_out_misalign;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a transaction-level model predicts bus requests and
// writeback results; literal pins fix the key load/store cases.
module tb_lsu_mem_stage;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] wdata;
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] rdata;
    int          rstall;
    int          ostall;
    logic        has_lit;
    logic [63:0] lit;
    logic [7:0]  lit_strb;
    logic        no_rsp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        mis;
    int          lat;
    int          acc;
    logic        has_lit;
    logic [63:0] lit;
  } out_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] rdata;
    logic        no_rsp;
    logic        has_lit;
    logic [7:0]  lit_strb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_alu_res = '0;
  logic [63:0] in_wdata = '0;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_req_we;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [63:0] out_data;
  logic        out_misalign;

  lsu_mem_stage dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_in_alu_res    (in_alu_res),
    .i_in_wdata      (in_wdata),
    .i_in_is_load    (in_is_load),
    .i_in_is_store   (in_is_store),
    .i_in_size       (in_size),
    .i_in_unsigned   (in_unsigned),
    .i_in_rd         (in_rd),
    .i_in_wen        (in_wen),
    .o_mem_req_valid (mem_req_valid),
    .i_mem_req_ready (mem_req_ready),
    .o_mem_req_addr  (mem_req_addr),
    .o_mem_req_we    (mem_req_we),
    .o_mem_req_wdata (mem_req_wdata),
    .o_mem_req_wstrb (mem_req_wstrb),
    .i_mem_rsp_valid (mem_rsp_valid),
    .i_mem_rsp_rdata (mem_rsp_rdata),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_rd        (out_rd),
    .o_out_wen       (out_wen),
    .o_out_data      (out_data),
    .o_out_misalign  (out_misalign)
  );

  always #5 clk = ~clk;

  vec_t        vecs[$];
  out_t        exp_out[$];
  req_t        exp_req[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          idx = 0;
  int          lim = 0;
  int          cyc = 0;
  int          rcnt = 0;
  int          ocnt = 0;
  bit          rsp_pend = 0;
  bit          first_seen = 0;
  logic [63:0] rsp_data = '0;

  function automatic vec_t mk(input logic [63:0] alu, input logic [63:0] wdata, input logic ld,
                              input logic st, input logic [1:0] sz, input logic uns,
                              input logic [4:0] rd, input logic wen, input logic [63:0] rdata,
                              input int rstall, input int ostall, input logic has_lit,
                              input logic [63:0] lit, input logic [7:0] lit_strb,
                              input logic no_rsp);
    vec_t v;
    v.alu = alu; v.wdata = wdata; v.ld = ld; v.st = st; v.sz = sz; v.uns = uns;
    v.rd = rd; v.wen = wen; v.rdata = rdata; v.rstall = rstall; v.ostall = ostall;
    v.has_lit = has_lit; v.lit = lit; v.lit_strb = lit_strb; v.no_rsp = no_rsp;
    return v;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input int off, input int nb,
                                         input logic uns);
    logic [63:0] v;
    logic [63:0] m;
    v = rdata >> (8 * off);
    if (nb == 8) return v;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s @cyc %0d: got event, want none", nm, cyc);
  endtask

  task automatic accept_model(input vec_t v);
    out_t o;
    req_t r;
    int   nb;
    int   off;
    bit   mem;
    nb  = 1 << v.sz;
    off = int'(v.alu[2:0]);
    mem = v.ld | v.st;
    o.rd = v.rd; o.acc = cyc; o.has_lit = v.has_lit; o.lit = v.lit;
    if (!mem) begin
      o.data = v.alu; o.wen = v.wen; o.mis = 1'b0; o.lat = 1;
    end else if ((off % nb) != 0) begin
      o.data = '0; o.wen = 1'b0; o.mis = 1'b1; o.lat = 1;
    end else begin
      r.addr = {v.alu[63:3], 3'b000};
      r.we = v.st & ~v.ld;
      r.wdata = v.wdata << (8 * off);
      r.strb = 8'(((1 << nb) - 1) << off);
      r.rdata = v.rdata; r.no_rsp = v.no_rsp;
      r.has_lit = v.has_lit & r.we; r.lit_strb = v.lit_strb;
      exp_req.push_back(r);
      o.data = v.ld ? m_load(v.rdata, off, nb, v.uns) : 64'd0;
      o.wen = v.ld & v.wen; o.mis = 1'b0; o.lat = 3 + v.rstall;
    end
    exp_out.push_back(o);
    rcnt = v.rstall;
    ocnt = v.ostall;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    mem_rsp_valid = rsp_pend;
    mem_rsp_rdata = rsp_pend ? rsp_data : 64'hDEAD_BEEF_0BAD_F00D;
    rsp_pend = 0;
    mem_req_ready = (rcnt == 0);
    if (mem_req_valid && rcnt > 0) rcnt--;
    out_ready = (ocnt == 0);
    if (out_valid && ocnt > 0) ocnt--;
    if (idx < lim) begin
      in_valid = 1'b1;
      in_alu_res = vecs[idx].alu; in_wdata = vecs[idx].wdata;
      in_is_load = vecs[idx].ld; in_is_store = vecs[idx].st;
      in_size = vecs[idx].sz; in_unsigned = vecs[idx].uns;
      in_rd = vecs[idx].rd; in_wen = vecs[idx].wen;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (mem_req_valid) begin
      if (exp_req.size() == 0) fail_now("req_spurious");
      else begin
        chk("req_addr", mem_req_addr, exp_req[0].addr);
        chk("req_we", 64'(mem_req_we), 64'(exp_req[0].we));
        chk("req_wdata", mem_req_wdata, exp_req[0].wdata);
        chk("req_wstrb", 64'(mem_req_wstrb), 64'(exp_req[0].strb));
      end
    end
    chk("in_ready", 64'(in_ready),
        (exp_out.size() == 0) ? 64'd1 : 64'(out_valid & out_ready));
    if (out_valid) begin
      if (exp_out.size() == 0) fail_now("out_spurious");
      else begin
        if (!first_seen) chk("latency", 64'(cyc - exp_out[0].acc), 64'(exp_out[0].lat));
        first_seen = 1;
        chk("out_data", out_data, exp_out[0].data);
        chk("out_rd", 64'(out_rd), 64'(exp_out[0].rd));
        chk("out_wen", 64'(out_wen), 64'(exp_out[0].wen));
        chk("out_misalign", 64'(out_misalign), 64'(exp_out[0].mis));
      end
    end
    if (mem_req_valid && mem_req_ready && exp_req.size() > 0) begin
      if (exp_req[0].has_lit) chk("pin_wstrb", 64'(mem_req_wstrb), 64'(exp_req[0].lit_strb));
      rsp_pend = !exp_req[0].no_rsp;
      rsp_data = exp_req[0].rdata;
      void'(exp_req.pop_front());
    end
    if (out_valid && out_ready && exp_out.size() > 0) begin
      if (exp_out[0].has_lit) chk("pin_data", out_data, exp_out[0].lit);
      void'(exp_out.pop_front());
      first_seen = 0;
    end
    if (in_valid && in_ready) begin
      accept_model(vecs[idx]);
      idx++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_wen"}, 64'(out_wen), 64'd0);
    chk({tag, "_out_misalign"}, 64'(out_misalign), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    chk({tag, "_req_addr"}, mem_req_addr, 64'd0);
    chk({tag, "_req_wdata"}, mem_req_wdata, 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int budget;
    // Expected values below are written out by hand; the model must agree with them.
    vecs.push_back(mk(64'h8000_0010, 0, 1, 0, 2'b11, 0, 5'd1, 1, 64'h1122_3344_5566_7788,
                      0, 0, 1, 64'h1122_3344_5566_7788, 8'h00, 0));
    vecs.push_back(mk(64'h8000_0013, 0, 1, 0, 2'b00, 0, 5'd2, 1, 64'h0000_0000_8000_0000,
                      0, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 0));
    vecs.push_back(mk(64'h8000_0013, 0, 1, 0, 2'b00, 1, 5'd3, 1, 64'h0000_0000_8000_0000,
                      0, 0, 1, 64'h0000_0000_0000_0080, 8'h00, 0));
    vecs.push_back(mk(64'h8000_0006, 64'hABCD, 0, 1, 2'b01, 0, 5'd4, 1, 64'h5555,
                      0, 0, 1, 64'd0, 8'hC0, 0));
    vecs.push_back(mk(64'h8000_0002, 0, 1, 0, 2'b10, 0, 5'd5, 1, 64'h7777,
                      0, 0, 1, 64'd0, 8'h00, 0));
    vecs.push_back(mk(64'h1000_000A, 0, 1, 0, 2'b01, 0, 5'd6, 1, 64'h0123_4567_89AB_CDEF,
                      3, 2, 1, 64'hFFFF_FFFF_FFFF_89AB, 8'h00, 0));
    vecs.push_back(mk(64'h2004, 64'h1234_5678, 0, 1, 2'b10, 0, 5'd7, 1, 64'h0,
                      1, 0, 1, 64'd0, 8'hF0, 0));
    vecs.push_back(mk(64'h2004, 0, 1, 0, 2'b10, 1, 5'd8, 1, 64'hF000_0001_0000_0000,
                      0, 0, 1, 64'h0000_0000_F000_0001, 8'h00, 0));
    vecs.push_back(mk(64'h2004, 0, 1, 0, 2'b10, 0, 5'd9, 1, 64'hF000_0001_0000_0000,
                      0, 0, 1, 64'hFFFF_FFFF_F000_0001, 8'h00, 0));
    vecs.push_back(mk(64'h3000, 64'h0102_0304_0506_0708, 0, 1, 2'b11, 0, 5'd10, 0, 64'hFFFF,
                      0, 0, 1, 64'd0, 8'hFF, 0));
    vecs.push_back(mk(64'h5, 0, 0, 0, 2'b00, 0, 5'd11, 1, 0, 0, 0, 1, 64'h5, 8'h00, 0));
    vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 2'b00, 0, 5'd12, 1, 0,
                      0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 8'h00, 0));
    vecs.push_back(mk(64'h1235, 0, 0, 0, 2'b11, 0, 5'd13, 0, 0, 0, 2, 1, 64'h1235, 8'h00, 0));
    vecs.push_back(mk(64'h42, 0, 0, 0, 2'b00, 0, 5'd14, 1, 0, 0, 0, 1, 64'h42, 8'h00, 0));
    vecs.push_back(mk(64'h3007, 64'hAA, 0, 1, 2'b00, 0, 5'd15, 1, 0, 0, 0, 1, 64'd0, 8'h80, 0));
    vecs.push_back(mk(64'h4000, 64'h9999, 1, 1, 2'b11, 0, 5'd16, 1, 64'hCAFE,
                      0, 0, 1, 64'hCAFE, 8'h00, 0));
    vecs.push_back(mk(64'h4004, 0, 1, 0, 2'b11, 0, 5'd17, 1, 0, 0, 0, 1, 64'd0, 8'h00, 0));
    vecs.push_back(mk(64'h4001, 0, 1, 0, 2'b01, 1, 5'd18, 1, 0, 0, 1, 1, 64'd0, 8'h00, 0));
    vecs.push_back(mk(64'h5000, 0, 1, 0, 2'b11, 0, 5'd19, 1, 64'h1, 0, 0, 0, 64'd0, 8'h00, 1));
    vecs.push_back(mk(64'h77, 0, 0, 0, 2'b00, 0, 5'd20, 1, 0, 0, 0, 1, 64'h77, 8'h00, 0));

    in_alu_res = 64'hFFFF_FFFF_FFFF_FFFF;
    in_wdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    lim = vecs.size() - 2;
    budget = 0;
    while ((idx < lim || exp_out.size() > 0) && budget < 500) begin
      cycle();
      budget++;
    end
    if (budget >= 500) fail_now("timeout_main");

    lim = lim + 1;
    budget = 0;
    while ((idx < lim || exp_req.size() > 0) && budget < 50) begin
      cycle();
      budget++;
    end
    if (budget >= 50) fail_now("timeout_rsp");

    // DUT now waits in RSP for a response that never comes; reset must clear it at once.
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    exp_out.delete();
    exp_req.delete();
    rsp_pend = 0; first_seen = 0; rcnt = 0; ocnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset("postrst");

    lim = vecs.size();
    budget = 0;
    while ((idx < lim || exp_out.size() > 0) && budget < 50) begin
      cycle();
      budget++;
    end
    if (budget >= 50) fail_now("timeout_tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
